// File: rtl/regfile_seq_pkg.sv
// Shared types and helpers for the register-file sequencer: FSM states,
// command field positions and the address-to-one-hot decode.
package regfile_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Command fields are packed {WrEn, Wa, RaB, RaA}; indices below are in
  // units of the address width, so field f starts at bit f*AW.
  localparam int RAA_FIELD  = 0;
  localparam int RAB_FIELD  = 1;
  localparam int WA_FIELD   = 2;
  localparam int WREN_FIELD = 3;

  // One bit of the one-hot decode: set only when the address is in range
  // and selects register idx. Out-of-range addresses never wrap.
  function automatic logic addr_hit(input int unsigned addr,
                                    input int unsigned idx,
                                    input int unsigned nreg);
    return (addr < nreg) && (addr == idx);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted last wins; the history only moves when a grant is accepted.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_reg;

  // Combinational grant from the current requests and the grant history.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) gnt_id = ~last_reg;
    else              gnt_id = req[1];
  end

  // Remember who was granted; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge Clk) begin
    if (Rst)     last_reg <= 1'b1;
    else if (en) last_reg <= gnt_id;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences register-transfer commands from two requesters through a shared
// register file: operand read, externally timed ALU step, write-back.
// Bus enables and strobes are registered, computed from the next state so
// they line up exactly with the state they belong to.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int AW    = 4,
  parameter int TMO   = 15,
  parameter int CMD_W = 3*AW+1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req0Valid,
  input  logic [CMD_W-1:0] Req0Cmd,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [CMD_W-1:0] Req1Cmd,
  output logic             Req1Ready,
  output logic [NREG-1:0]  Oe0,
  output logic [NREG-1:0]  Oe1,
  output logic [NREG-1:0]  Ld,
  output logic             AluStart,
  input  logic             AluDone,
  output logic             Done,
  output logic             Err,
  output logic             GntId,
  output logic             Busy
);

  localparam int TW = $clog2(TMO + 1);

  state_t           state_reg, state_next;
  logic [CMD_W-1:0] cmd_reg, cmd_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic             gnt_next;
  logic             accept;
  logic             timeout;
  logic             gnt_valid, gnt_id;
  logic [NREG-1:0]  oe0_dec, oe1_dec, ld_dec;
  logic [AW-1:0]    raa_next, rab_next, wa_next;
  logic             wren_next;

  rr_arb2 u_arb (
    .Clk      (Clk),
    .Rst      (Rst),
    .req      ({Req1Valid, Req0Valid}),
    .en       (accept),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  assign accept    = (state_reg == IDLE) && gnt_valid && !Rst;
  assign Req0Ready = accept && !gnt_id;
  assign Req1Ready = accept &&  gnt_id;
  assign Busy      = (state_reg != IDLE);

  assign raa_next  = cmd_next[RAA_FIELD*AW +: AW];
  assign rab_next  = cmd_next[RAB_FIELD*AW +: AW];
  assign wa_next   = cmd_next[WA_FIELD*AW  +: AW];
  assign wren_next = cmd_next[WREN_FIELD*AW];

  // Per-register decode of the command that will be current next cycle.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    assign oe0_dec[gi] = addr_hit(32'(raa_next), gi, NREG);
    assign oe1_dec[gi] = addr_hit(32'(rab_next), gi, NREG);
    assign ld_dec[gi]  = addr_hit(32'(wa_next),  gi, NREG);
  end

  // Next-state logic: accept in IDLE, one READ cycle, bounded EXEC, WRITE.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    tmo_next   = tmo_reg;
    gnt_next   = GntId;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cmd_next   = gnt_id ? Req1Cmd : Req0Cmd;
          gnt_next   = gnt_id;
          state_next = READ;
        end
      end
      READ: begin
        tmo_next   = '0;
        state_next = EXEC;
      end
      EXEC: begin
        if (AluDone) begin
          state_next = WRITE;
        end else if (tmo_reg == TW'(TMO - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, command and registered outputs; reset drops any command in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      cmd_reg   <= '0;
      tmo_reg   <= '0;
      GntId     <= 1'b0;
      Oe0       <= '0;
      Oe1       <= '0;
      Ld        <= '0;
      AluStart  <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      tmo_reg   <= tmo_next;
      GntId     <= gnt_next;
      Oe0       <= (state_next != IDLE) ? oe0_dec : '0;
      Oe1       <= (state_next != IDLE) ? oe1_dec : '0;
      Ld        <= (state_next == WRITE && wren_next) ? ld_dec : '0;
      AluStart  <= (state_next == READ);
      Done      <= (state_next == WRITE);
      Err       <= timeout;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer (12-register file, 4-bit addresses).
module tb_regfile_sequencer;

  localparam int NREG  = 12;
  localparam int AW    = 4;
  localparam int TMO   = 15;
  localparam int CMD_W = 3*AW+1;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic [CMD_W-1:0] Req0Cmd = '0, Req1Cmd = '0;
  logic             Req0Ready, Req1Ready;
  logic [NREG-1:0]  Oe0, Oe1, Ld;
  logic             AluStart, AluDone = 1'b0, Done, Err, GntId, Busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  regfile_sequencer #(.NREG(NREG), .AW(AW), .TMO(TMO), .CMD_W(CMD_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0Valid(Req0Valid), .Req0Cmd(Req0Cmd), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Cmd(Req1Cmd), .Req1Ready(Req1Ready),
    .Oe0(Oe0), .Oe1(Oe1), .Ld(Ld),
    .AluStart(AluStart), .AluDone(AluDone),
    .Done(Done), .Err(Err), .GntId(GntId), .Busy(Busy)
  );

  function automatic logic [CMD_W-1:0] mk(input logic wren, input int wa, input int rab, input int raa);
    return {wren, AW'(wa), AW'(rab), AW'(raa)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Cycle-by-cycle invariants on the enables and strobes.
  always @(negedge Clk) begin
    if (!Rst) begin
      tests_run++;
      if ($countones(Oe0) > 1 || $countones(Oe1) > 1 || $countones(Ld) > 1 ||
          (!Busy && (Oe0 != '0 || Oe1 != '0)) || (Ld != '0 && !Done)) begin
        tests_failed++;
        $display("FAIL invariant t=%0t Busy=%b Oe0=%h Oe1=%h Ld=%h Done=%b", $time, Busy, Oe0, Oe1, Ld, Done);
      end
    end
  end

  task automatic test_reset();
    Rst = 1'b1; Req0Valid = 0; Req1Valid = 0; AluDone = 0;
    tick(); tick();
    Rst = 1'b0;
    #1;
    tests_run++;
    if ({Oe0, Oe1, Ld} !== '0 || {AluStart, Done, Err, GntId, Busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs Oe0=%h Oe1=%h Ld=%h St/Dn/Er/G/B=%b%b%b%b%b required all 0",
               Oe0, Oe1, Ld, AluStart, Done, Err, GntId, Busy);
    end
    tick();
    tests_run++;
    if (Busy !== 1'b0 || Req0Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle Busy=%b Req0Ready=%b required 0 0", Busy, Req0Ready);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_basic();
    Req0Cmd = mk(1, 5, 2, 3); Req0Valid = 1; #1;
    tests_run++;
    if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ready Req0Ready=%b Req1Ready=%b required 1 0", Req0Ready, Req1Ready);
    end
    tick(); Req0Valid = 0;                         // READ
    tests_run++;
    if (Oe0 !== 12'h008 || Oe1 !== 12'h004 || AluStart !== 1'b1 || Ld !== '0 || Req0Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_read Oe0=%h Oe1=%h AluStart=%b Ld=%h Rdy=%b required 008 004 1 000 0",
               Oe0, Oe1, AluStart, Ld, Req0Ready);
    end
    tick(); AluDone = 1;                           // EXEC
    tests_run++;
    if (Oe0 !== 12'h008 || Oe1 !== 12'h004 || AluStart !== 1'b0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_exec Oe0=%h Oe1=%h AluStart=%b Done=%b required 008 004 0 0",
               Oe0, Oe1, AluStart, Done);
    end
    tick(); AluDone = 0;                           // WRITE
    tests_run++;
    if (Ld !== 12'h020 || Done !== 1'b1 || Oe0 !== 12'h008 || Oe1 !== 12'h004 || GntId !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_write Ld=%h Done=%b Oe0=%h Oe1=%h GntId=%b required 020 1 008 004 0",
               Ld, Done, Oe0, Oe1, GntId);
    end
    tick();                                        // IDLE
    tests_run++;
    if (Ld !== '0 || Done !== 1'b0 || Busy !== 1'b0 || Oe0 !== '0) begin
      tests_failed++;
      $display("FAIL basic_idle Ld=%h Done=%b Busy=%b Oe0=%h required 000 0 0 000", Ld, Done, Busy, Oe0);
    end
    $display("[TB] basic: cmd req0 wr r5 <- r3,r2 completed");
  endtask

  task automatic test_back_to_back();
    logic [NREG-1:0] exp_oe0, exp_ld;
    logic exp_g;
    Rst = 1; tick(); Rst = 0;
    Req0Cmd = mk(1, 3, 2, 1);
    Req1Cmd = mk(1, 8, 6, 4);
    Req0Valid = 1; Req1Valid = 1; AluDone = 1;
    for (int i = 0; i < 4; i++) begin
      exp_g   = (i % 2 == 1);
      exp_oe0 = exp_g ? 12'h010 : 12'h002;
      exp_ld  = exp_g ? 12'h100 : 12'h008;
      #1;
      tests_run++;
      if (Req0Ready !== !exp_g || Req1Ready !== exp_g) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d] Req0Ready=%b Req1Ready=%b required %b %b",
                 i, Req0Ready, Req1Ready, !exp_g, exp_g);
      end
      tick();                                      // READ
      tests_run++;
      if (GntId !== exp_g || Oe0 !== exp_oe0 || Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d] GntId=%b Oe0=%h rdy=%b%b required %b %h 00",
                 i, GntId, Oe0, Req0Ready, Req1Ready, exp_g, exp_oe0);
      end
      tick(); tick();                              // EXEC, WRITE
      tests_run++;
      if (Ld !== exp_ld || Done !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_write[%0d] Ld=%h Done=%b required %h 1", i, Ld, Done, exp_ld);
      end
      tick();                                      // IDLE
      $display("[TB] b2b: transaction %0d granted to requester %0d", i, exp_g);
    end
    Req0Valid = 0; Req1Valid = 0; AluDone = 0;
  endtask

  task automatic test_same_reg();
    Req0Cmd = mk(0, 9, 7, 7); Req0Valid = 1;
    tick(); Req0Valid = 0;                         // READ
    tests_run++;
    if (Oe0 !== 12'h080 || Oe1 !== 12'h080) begin
      tests_failed++;
      $display("FAIL same_reg_oe Oe0=%h Oe1=%h required 080 080", Oe0, Oe1);
    end
    tick(); AluDone = 1;                           // EXEC
    tick(); AluDone = 0;                           // WRITE
    tests_run++;
    if (Ld !== '0 || Done !== 1'b1 || Oe1 !== 12'h080) begin
      tests_failed++;
      $display("FAIL same_reg_write Ld=%h Done=%b Oe1=%h required 000 1 080", Ld, Done, Oe1);
    end
    tick();
    $display("[TB] same_reg: r7,r7 no write-back completed");
  endtask

  task automatic test_timeout();
    int n;
    Req1Cmd = mk(1, 2, 1, 0); Req1Valid = 1; AluDone = 0;
    tick(); Req1Valid = 0;                         // READ
    tick();                                        // first EXEC
    n = 0;
    while (Busy && n < 40) begin
      tests_run++;
      if (Err !== 1'b0 || Ld !== '0 || Done !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_exec[%0d] Err=%b Ld=%h Done=%b required 0 000 0", n, Err, Ld, Done);
      end
      n++;
      tick();
    end
    tests_run++;
    if (n != TMO || Err !== 1'b1 || Busy !== 1'b0 || Ld !== '0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_abort cycles=%0d Err=%b Busy=%b Ld=%h Done=%b required %0d 1 0 000 0",
               n, Err, Busy, Ld, Done, TMO);
    end
    tick();
    tests_run++;
    if (Err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_err_pulse Err=%b required 0", Err);
    end
    Req0Cmd = mk(1, 4, 1, 0); Req0Valid = 1;
    tick(); Req0Valid = 0;
    tick(); AluDone = 1;
    tick(); AluDone = 0;
    tests_run++;
    if (Ld !== 12'h010 || Done !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_recover Ld=%h Done=%b required 010 1", Ld, Done);
    end
    tick();
    $display("[TB] timeout: aborted after %0d EXEC cycles, next command ok", n);
  endtask

  task automatic test_out_of_range();
    AluDone = 1;
    tick(); AluDone = 0;
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_aludone Busy=%b Done=%b Err=%b required 0 0 0", Busy, Done, Err);
    end
    Req0Cmd = mk(1, 14, 13, 0); Req0Valid = 1;
    tick(); Req0Valid = 0;                         // READ
    tests_run++;
    if (Oe0 !== 12'h001 || Oe1 !== '0) begin
      tests_failed++;
      $display("FAIL oor_read Oe0=%h Oe1=%h required 001 000", Oe0, Oe1);
    end
    tick(); AluDone = 1;
    tick(); AluDone = 0;                           // WRITE
    tests_run++;
    if (Ld !== '0 || Done !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_write Ld=%h Done=%b required 000 1", Ld, Done);
    end
    tick();
    $display("[TB] out_of_range: Wa=14 RaB=13 completed without strobes");
  endtask

  task automatic test_reset_mid();
    Req1Cmd = mk(1, 6, 5, 4); Req1Valid = 1;
    tick(); Req1Valid = 0;                         // READ
    tick();                                        // EXEC
    Rst = 1;
    tick(); Rst = 0;
    tests_run++;
    if (Busy !== 1'b0 || Oe0 !== '0 || Oe1 !== '0 || Done !== 1'b0 || Err !== 1'b0 || GntId !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid Busy=%b Oe0=%h Oe1=%h Done=%b Err=%b GntId=%b required 0 000 000 0 0 0",
               Busy, Oe0, Oe1, Done, Err, GntId);
    end
    AluDone = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (Done !== 1'b0 || Err !== 1'b0 || Busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_quiet[%0d] Done=%b Err=%b Busy=%b required 0 0 0", i, Done, Err, Busy);
      end
    end
    AluDone = 0;
    $display("[TB] reset_mid: command dropped");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_same_reg();
    test_timeout();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Controller that shares one register file between two requesters. The register file is built from N-bit registers, each with a load strobe and two tri-state output enables (read buses 0 and 1). The block round-robin arbitrates register-transfer commands and drives the one-hot Oe0/Oe1/Ld vectors. It sequences each command through operand read, an externally timed ALU step, and write-back, so no read bus ever has two drivers.

## Interface
Parameters:
- NREG, 16, number of registers in the file
- AW, 4, register address width; NREG ≤ 2**AW
- TMO, 15, max EXEC cycles waiting for AluDone before abort
- CMD_W, 3*AW+1, packed command width

Ports:
- Clk  in  1  clock; all state changes on posedge
- Rst  in  1  reset; synchronous, active-high
- Req0Valid  in  1  requester 0 command valid
- Req0Cmd  in  CMD_W  {WrEn, Wa, RaB, RaA}, RaA in LSBs
- Req0Ready  out  1  requester 0 command accepted this cycle
- Req1Valid, Req1Cmd, Req1Ready  same as above, for requester 1
- Oe0  out  NREG  one-hot read-bus-0 enable (register RaA)
- Oe1  out  NREG  one-hot read-bus-1 enable (register RaB)
- Ld  out  NREG  one-hot load strobe (register Wa)
- AluStart  out  1  single-cycle pulse: operands valid on buses
- AluDone  in  1  ALU result valid on register-file input
- Done  out  1  single-cycle pulse: command completed
- Err  out  1  single-cycle pulse: command aborted by timeout
- GntId  out  1  requester owning the current command
- Busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- **IDLE:**
  - Arbitrate if any ReqNValid.
  - Both valid: grant the requester not granted last. LastGnt resets to 1, so requester 0 wins the first tie.
  - ReqNReady is combinational: high only in IDLE, for the granted requester only.
  - Command latched into CmdReg and GntId updated on the accept edge. Next state READ.
- **READ:**
  - Oe0[RaA] = 1 and Oe1[RaB] = 1; RaA = RaB is legal (both buses driven by the same register).
  - AluStart = 1. Next state EXEC.
- **EXEC:**
  - Oe held; tmo counter increments each cycle.
  - AluDone = 1 → WRITE.
  - Counter reaches TMO without AluDone → IDLE, with Err pulsed in that transition cycle. No Ld is issued.
- **WRITE:**
  - Oe held.
  - Ld[Wa] = 1 if WrEn, else Ld stays all-zero.
  - Done = 1. Next state IDLE.
- Addresses ≥ NREG:
  - Corresponding Oe/Ld bits are all-zero; no wrap-around.
  - Command still completes with Done.
- Invariants, every cycle:
  - Oe0, Oe1, Ld each at most one bit set.
  - Oe all-zero in IDLE.
  - Ld nonzero only in WRITE.
- AluDone is ignored outside EXEC.
- ReqNValid is ignored outside IDLE; the requester holds it until Ready.
- **Reset:**
  - Any state → IDLE.
  - Oe0 = Oe1 = Ld = 0; AluStart = Done = Err = 0; Busy = 0; GntId = 0.
  - LastGnt = 1; tmo counter = 0; CmdReg = 0.
  - Reset mid-command drops the command silently; no Done and no Err.

## Timing
- Accept at edge t (IDLE, Valid & Ready).
- READ in cycle t+1.
- EXEC from t+2.
- AluDone sampled high in EXEC cycle t+1+k → WRITE in cycle t+2+k → IDLE in cycle t+3+k.
- Minimum 4 cycles per command (accept, READ, EXEC, WRITE), with AluDone in the first EXEC cycle.
- Next accept is possible in the first IDLE cycle after WRITE.
- All outputs are registered except ReqNReady and Busy; those are decoded from the state register and valid inputs.

## Structure
- Package regfile_seq_pkg:
  - state enum (IDLE/READ/EXEC/WRITE)
  - command field offsets
  - function decoding AW-bit address to NREG one-hot with range check
- Sub-module rr_arb2: 2-requester round-robin arbiter with LastGnt register; update enable = accept.
- FSM, CmdReg, tmo counter and decoders live in the top level.

## Test plan
- Reset then idle: all outputs 0, Busy 0; hold Rst mid-EXEC → next cycle IDLE, Oe = 0, no Done/Err.
- Req0 {WrEn=1, Wa=5, RaB=2, RaA=3}, AluDone one cycle after AluStart:
  - Oe0 = 0x0008 and Oe1 = 0x0004 from READ through WRITE.
  - Ld = 0x0020 for exactly one cycle, coincident with Done.
  - 4 cycles total.
- Both requesters valid continuously: grants alternate 0,1,0,1; each ReqReady pulses once per grant; no overlapping Oe.
- WrEn=0 command, RaA = RaB = 7: Oe0 = Oe1 = 0x0080; Ld stays 0; Done pulses.
- AluDone never asserted: exactly TMO EXEC cycles, Err pulse, no Ld, return to IDLE; next command accepted normally.
- NREG=12, Wa=14: Ld all-zero in WRITE, Done still pulses; AluDone pulsed in IDLE is ignored (no state change).
